// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: merges reset requests into one stretched event, then releases rst_out[0..NOUT-1] staggered.
// Define RST_SEQ_CTRL_WDOG_EN to add a watchdog that counts in RUN and fires when it saturates.
module rst_seq_ctrl #(
  parameter int NREQ     = 2,
  parameter int NOUT     = 2,
  parameter int STRETCH  = 5,
  parameter int STAGGER  = 4,
  parameter int PERIOD_W = 14,
  parameter int WDOG_W   = 20
) (
  input  logic            ck,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            periodic_en,
  input  logic            wdog_kick,
  output logic [NOUT-1:0] rst_out,
  output logic            busy,
  output logic [NREQ+2:0] cause
);
  typedef enum logic [1:0] {ASSERT, RELEASE, RUN} state_t;
  localparam int CW = $clog2(STRETCH + 1);
  localparam int SW = STAGGER > 0 ? $clog2(STAGGER + 1) : 1;
  state_t state;
  logic [CW-1:0] cnt;
  logic [SW-1:0] sc;
  logic [PERIOD_W-1:0] pcnt;
  logic per, wd, ev;
  logic [NREQ+2:0] src;
  logic [NOUT-1:0] nxt_out;
  assign per = periodic_en & (&pcnt);
  assign src = {wd, per, req, 1'b0};
  assign ev = |src;
  assign busy = state != RUN;
  // bits release from index 0 upward by shifting zeros in from the bottom
  assign nxt_out = STAGGER == 0 ? '0 : rst_out << 1;
`ifdef RST_SEQ_CTRL_WDOG_EN
  logic [WDOG_W-1:0] wcnt;
  assign wd = &wcnt;
  always_ff @(posedge ck or posedge rst)
    if (rst) wcnt <= '0;
    else wcnt <= (state != RUN || wdog_kick || wd) ? '0 : wcnt + 1'b1;
`else
  logic unused_wdog;
  assign wd = 1'b0;
  assign unused_wdog = wdog_kick | (WDOG_W == 0);
`endif
  always_ff @(posedge ck or posedge rst)
    if (rst) begin
      state   <= ASSERT;
      rst_out <= '1;
      cause   <= {{(NREQ+2){1'b0}}, 1'b1};
      cnt     <= CW'(STRETCH);
      sc      <= '0;
      pcnt    <= '0;
    end else begin
      pcnt <= pcnt + PERIOD_W'(periodic_en);
      if (ev) cause <= (state == RUN ? '0 : cause) | src;
      if (ev) begin
        state   <= ASSERT;
        rst_out <= '1;
        cnt     <= CW'(STRETCH);
      end else if (state == ASSERT) begin
        cnt <= cnt - 1'b1;
        if (cnt == CW'(1)) begin
          rst_out <= nxt_out;
          sc      <= SW'(STAGGER);
          state   <= nxt_out == '0 ? RUN : RELEASE;
        end
      end else if (state == RELEASE) begin
        sc <= sc - 1'b1;
        if (sc == SW'(1)) begin
          rst_out <= nxt_out;
          sc      <= SW'(STAGGER);
          if (nxt_out == '0) state <= RUN;
        end
      end
    end
endmodule
